stack_alu_seq: RTL

- Execute stage directly upstream of the data stack: takes the opcode of one Forth primitive plus the current stack T/N values.
- Issues the stack's write commands: TWrite, NWrite, WData, Offset.
- Multi-cycle sequencer: iterative multiply/divide, and a second write cycle for two-result ops, because the stack has a single WData port.
- Start/Busy/Done handshake with the fetch/decode controller.

---
 rtl/stack_alu_seq.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/stack_alu_seq.sv
// Execute stage for Forth primitives: turns an opcode plus T/N into stack write commands,
// sequencing shift-add multiply, restoring divide and the second write of two-result ops.
module stack_alu_seq #(
  parameter int W    = 16,
  parameter int ITER = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Start,
  input  logic [3:0]   Op,
  input  logic [W-1:0] T,
  input  logic [W-1:0] N,
  output logic         Busy,
  output logic         Done,
  output logic         TWrite,
  output logic         NWrite,
  output logic [W-1:0] WData,
  output logic [1:0]   Offset
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [3:0] OP_NOP = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4,  OP_XOR = 4'd5,  OP_INV = 4'd6,  OP_DUP = 4'd7;
  localparam logic [3:0] OP_DROP = 4'd8, OP_SWAP = 4'd9, OP_OVER = 4'd10, OP_MUL = 4'd11;
  localparam logic [3:0] OP_UMSTAR = 4'd12, OP_DIVMOD = 4'd13, OP_LT = 4'd14, OP_ZEQ = 4'd15;

  localparam logic [1:0] OFF_NONE = 2'b00, OFF_PUSH = 2'b01, OFF_POP = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_ITER, S_WR_T, S_WR_N} state_t;

  state_t       r_state, w_state_nx;
  logic [3:0]   r_op;
  logic [W-1:0] r_b;
  logic [W-1:0] r_hi;
  logic [W-1:0] r_lo;
  logic [CW-1:0] r_cnt;

  logic         r_busy, r_done, r_tw, r_nw;
  logic [W-1:0] r_wdata;
  logic [1:0]   r_off;

  logic         w_busy_nx, w_done_nx, w_tw_nx, w_nw_nx;
  logic [W-1:0] w_wdata_nx;
  logic [1:0]   w_off_nx;

  logic [W:0]   w_mul_sum;
  logic [W:0]   w_rem_sh;
  logic [W-1:0] w_rem_sub;
  logic         w_rem_ge;
  logic [W-1:0] w_hi_step;
  logic [W-1:0] w_lo_step;
  logic         w_last;

  // r_hi/r_lo hold {product high, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(W+1){1'b0}});
    w_rem_sh  = {r_hi, r_lo[W-1]};
    w_rem_ge  = (w_rem_sh >= {1'b0, r_b});
    w_rem_sub = w_rem_sh[W-1:0] - r_b;
    if (r_op == OP_DIVMOD) begin
      w_hi_step = w_rem_ge ? w_rem_sub : w_rem_sh[W-1:0];
      w_lo_step = {r_lo[W-2:0], w_rem_ge};
    end else begin
      w_hi_step = w_mul_sum[W:1];
      w_lo_step = {w_mul_sum[0], r_lo[W-1:1]};
    end
  end

  assign w_last = (r_cnt == CW'(ITER - 1));

  always_comb begin
    w_state_nx = r_state;
    w_done_nx  = 1'b0;
    w_tw_nx    = 1'b0;
    w_nw_nx    = 1'b0;
    w_wdata_nx = '0;
    w_off_nx   = OFF_NONE;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          if (Op == OP_SWAP) begin
            w_state_nx = S_WR_T;
            w_tw_nx    = 1'b1;
            w_wdata_nx = N;
          end else if (Op == OP_MUL || Op == OP_UMSTAR || Op == OP_DIVMOD) begin
            w_state_nx = S_ITER;
          end else begin
            w_state_nx = S_EXEC;
            w_done_nx  = 1'b1;
            case (Op)
              OP_ADD:  begin w_tw_nx = 1'b1; w_wdata_nx = N + T; w_off_nx = OFF_POP; end
              OP_SUB:  begin w_tw_nx = 1'b1; w_wdata_nx = N - T; w_off_nx = OFF_POP; end
              OP_AND:  begin w_tw_nx = 1'b1; w_wdata_nx = N & T; w_off_nx = OFF_POP; end
              OP_OR:   begin w_tw_nx = 1'b1; w_wdata_nx = N | T; w_off_nx = OFF_POP; end
              OP_XOR:  begin w_tw_nx = 1'b1; w_wdata_nx = N ^ T; w_off_nx = OFF_POP; end
              OP_INV:  begin w_tw_nx = 1'b1; w_wdata_nx = ~T; end
              OP_DUP:  begin w_tw_nx = 1'b1; w_wdata_nx = T; w_off_nx = OFF_PUSH; end
              OP_DROP: w_off_nx = OFF_POP;
              OP_OVER: begin w_tw_nx = 1'b1; w_wdata_nx = N; w_off_nx = OFF_PUSH; end
              OP_LT: begin
                w_tw_nx    = 1'b1;
                w_wdata_nx = ($signed(N) < $signed(T)) ? '1 : '0;
                w_off_nx   = OFF_POP;
              end
              OP_ZEQ:  begin w_tw_nx = 1'b1; w_wdata_nx = (T == '0) ? '1 : '0; end
              default: ;
            endcase
          end
        end
      end
      S_EXEC: w_state_nx = S_IDLE;
      S_ITER: begin
        if (w_last) begin
          w_state_nx = S_WR_T;
          w_tw_nx    = 1'b1;
          if (r_op == OP_MUL) begin
            w_wdata_nx = w_lo_step;
            w_off_nx   = OFF_POP;
            w_done_nx  = 1'b1;
          end else if (r_op == OP_UMSTAR) begin
            w_wdata_nx = w_hi_step;
          end else begin
            w_wdata_nx = w_lo_step;
          end
        end
      end
      S_WR_T: begin
        if (r_op == OP_MUL) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_WR_N;
          w_nw_nx    = 1'b1;
          w_done_nx  = 1'b1;
          if (r_op == OP_SWAP)        w_wdata_nx = r_b;
          else if (r_op == OP_UMSTAR) w_wdata_nx = r_lo;
          else                        w_wdata_nx = r_hi;
        end
      end
      S_WR_N: w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tw    <= 1'b0;
      r_nw    <= 1'b0;
      r_wdata <= '0;
      r_off   <= OFF_NONE;
      r_op    <= OP_NOP;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
      r_tw    <= w_tw_nx;
      r_nw    <= w_nw_nx;
      r_wdata <= w_wdata_nx;
      r_off   <= w_off_nx;
      if (r_state == S_IDLE && Start) begin
        r_op  <= Op;
        r_b   <= T;
        r_hi  <= '0;
        r_lo  <= N;
        r_cnt <= '0;
      end else if (r_state == S_ITER) begin
        r_hi  <= w_hi_step;
        r_lo  <= w_lo_step;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign Busy   = r_busy;
  assign Done   = r_done;
  assign TWrite = r_tw;
  assign NWrite = r_nw;
  assign WData  = r_wdata;
  assign Offset = r_off;

endmodule
